// File: rtl/dmem_port_arbiter_if.sv
// Request/response port used by each data-memory requester (CPU MEM stage and
// the DMA/debug loader).
//   master modport : requester side, drives req/we/addr/wdata/funct3 and
//                    receives gnt/rvalid/rdata
//   slave modport  : arbiter side, the mirror image
// Parameters: ADDR_W byte address width, DATA_W data width.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        funct3;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, funct3,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a
// DMA/debug loader. At most one access is issued per cycle and the read data,
// which returns one cycle after the read strobe, is routed back to the port
// that issued the read. cpu_stall tells the hazard logic the CPU was denied.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   cpu, dma     requester ports (dmem_port_arbiter_if.slave)
//   dma_lock     DMA asks for burst ownership of the port
//   cpu_stall    CPU is requesting but not granted this cycle
//   mem_rd/wr    memory read/write strobes
//   mem_addr/wdata/funct3  fields of the granted request (0 when idle)
//   mem_rdata    memory read data, valid one cycle after mem_rd
//
// state    | meaning
// ARB      | round-robin between CPU and DMA, last_gnt loses ties
// DMA_LOCK | DMA owns the port while it keeps dma_lock and dma_req high;
//          | CPU breaks in once burst_cnt reaches MAX_BURST
module dmem_port_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  dmem_port_arbiter_if.slave cpu,
  dmem_port_arbiter_if.slave dma,
  input  logic              dma_lock,
  output logic              cpu_stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

  typedef enum logic {ARB, DMA_LOCK} state_t;

  state_t            state, state_next;
  logic              last_gnt;   // 0 = CPU, 1 = DMA
  logic [CNT_W-1:0]  burst_cnt, burst_next;
  logic              resp_pend;
  logic              resp_src;   // 0 = CPU, 1 = DMA
  logic              gnt_cpu, gnt_dma;
  logic              cpu_rvalid, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;

  // State register and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
      resp_pend <= 1'b0;
      resp_src  <= 1'b0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      if (gnt_cpu)
        last_gnt <= 1'b0;
      else if (gnt_dma)
        last_gnt <= 1'b1;
      resp_pend <= mem_rd;
      resp_src  <= gnt_dma;
    end
  end

  // Next-state logic. Any cycle without a locked DMA grant falls back to ARB.
  always_comb begin
    state_next = ARB;
    burst_next = '0;
    unique case (state)
      ARB: begin
        if (gnt_dma && dma_lock) begin
          state_next = DMA_LOCK;
          burst_next = BURST_ONE;
        end
      end
      DMA_LOCK: begin
        if (gnt_dma && dma_lock) begin
          state_next = DMA_LOCK;
          burst_next = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BURST_ONE;
        end
      end
      default: begin
        state_next = ARB;
        burst_next = '0;
      end
    endcase
  end

  // Output logic: grant decision, memory mux and response routing.
  // Everything is forced low during the reset cycle, including responses
  // still pending from before reset.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if (!reset) begin
      if (state == DMA_LOCK && dma_lock && dma.req) begin
        if (cpu.req && burst_cnt == BURST_MAX)
          gnt_cpu = 1'b1;
        else
          gnt_dma = 1'b1;
      end else if (cpu.req && dma.req) begin
        if (last_gnt)
          gnt_cpu = 1'b1;
        else
          gnt_dma = 1'b1;
      end else begin
        gnt_cpu = cpu.req;
        gnt_dma = dma.req;
      end
    end

    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    if (gnt_cpu) begin
      mem_rd     = ~cpu.we;
      mem_wr     = cpu.we;
      mem_addr   = cpu.addr;
      mem_wdata  = cpu.wdata;
      mem_funct3 = cpu.funct3;
    end else if (gnt_dma) begin
      mem_rd     = ~dma.we;
      mem_wr     = dma.we;
      mem_addr   = dma.addr;
      mem_wdata  = dma.wdata;
      mem_funct3 = dma.funct3;
    end

    cpu_rvalid = ~reset & resp_pend & ~resp_src;
    dma_rvalid = ~reset & resp_pend & resp_src;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
    cpu_stall  = ~reset & cpu.req & ~gnt_cpu;
  end

  assign cpu.gnt    = gnt_cpu;
  assign dma.gnt    = gnt_dma;
  assign cpu.rvalid = cpu_rvalid;
  assign dma.rvalid = dma_rvalid;
  assign cpu.rdata  = cpu_rdata;
  assign dma.rdata  = dma_rdata;

endmodule
